// File: rtl/sdrc_arb_pkg.sv
// Shared types and constants for the SDRAM application-port arbiter.
// Build macro SDRC_ARB_PORT0_PRIO_EN: port 0 becomes fixed-highest priority.
package sdrc_arb_pkg;

    localparam int unsigned ARB_MAX_NP = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WDAT = 2'd2,
        ARB_RDAT = 2'd3
    } arb_state_e;

`ifdef SDRC_ARB_PORT0_PRIO_EN
    localparam bit ARB_PORT0_PRIO = 1'b1;
`else
    localparam bit ARB_PORT0_PRIO = 1'b0;
`endif

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin picker: first requester after i_rr_ptr wins.
// With SDRC_ARB_PORT0_PRIO_EN, port 0 always wins and 1..NP-1 rotate.
module sdrc_rr_pick
    import sdrc_arb_pkg::*;
#(
    parameter int unsigned NP = 4,
    parameter int unsigned IW = 2
) (
    input  logic [NP-1:0] i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [NP-1:0] o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [NP-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_any;

    always_comb begin
        logic [IW-1:0] w_cand;
        w_gnt  = '0;
        w_idx  = '0;
        w_any  = 1'b0;
        w_cand = '0;
        // Scan rr_ptr+1 .. rr_ptr+NP modulo NP; port 0 excluded in priority mode.
        for (int unsigned k = 1; k <= NP; k++) begin
            w_cand = IW'((32'(i_rr_ptr) + k) % NP);
            if (!w_any && i_req[w_cand] && !(ARB_PORT0_PRIO && (w_cand == '0))) begin
                w_any         = 1'b1;
                w_idx         = w_cand;
                w_gnt[w_cand] = 1'b1;
            end
        end
        if (ARB_PORT0_PRIO && i_req[0]) begin
            w_gnt = NP'(1);
            w_idx = '0;
            w_any = 1'b1;
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_any = w_any;

endmodule

// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing the SDRAM controller application port among NP requesters.
// One whole burst in flight at a time; build macro SDRC_ARB_PORT0_PRIO_EN gives port 0 priority.
module sdrc_app_arb
    import sdrc_arb_pkg::*;
#(
    parameter int unsigned NP     = 4,
    parameter int unsigned APP_AW = 26,
    parameter int unsigned APP_DW = 32,
    parameter int unsigned APP_BW = 4,
    parameter int unsigned BL     = 9
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    input  logic [NP-1:0]        p_req,
    input  logic [NP*APP_AW-1:0] p_addr,
    input  logic [NP*BL-1:0]     p_len,
    input  logic [NP-1:0]        p_wr_n,
    output logic [NP-1:0]        p_ack,
    input  logic [NP*APP_DW-1:0] p_wr_data,
    input  logic [NP*APP_BW-1:0] p_wr_en_n,
    output logic [NP-1:0]        p_wr_next,
    output logic [NP-1:0]        p_rd_valid,
    output logic [NP-1:0]        p_last,
    output logic [APP_DW-1:0]    p_rd_data,
    output logic                 app_req,
    output logic [APP_AW-1:0]    app_req_addr,
    output logic [BL-1:0]        app_req_len,
    output logic                 app_req_wr_n,
    input  logic                 app_req_ack,
    output logic [APP_DW-1:0]    app_wr_data,
    output logic [APP_BW-1:0]    app_wr_en_n,
    input  logic                 app_wr_next_req,
    input  logic                 app_rd_valid,
    input  logic                 app_last_rd,
    input  logic                 app_last_wr,
    input  logic [APP_DW-1:0]    app_rd_data,
    output logic                 arb_busy,
    output logic [NP-1:0]        arb_gnt
);

    localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;

    if (NP < 2 || NP > ARB_MAX_NP) begin : g_bad_np
        $error("sdrc_app_arb: NP out of supported range");
    end

    arb_state_e        r_state, w_state_nxt;
    logic [NP-1:0]     r_gnt, w_gnt_nxt;
    logic [IW-1:0]     r_gidx, w_gidx_nxt;
    logic [IW-1:0]     r_rr_ptr, w_rr_nxt;
    logic [APP_AW-1:0] r_addr, w_addr_nxt;
    logic [BL-1:0]     r_len, w_len_nxt;
    logic              r_wr_n, w_wr_n_nxt;
    logic [BL-1:0]     r_cnt, w_cnt_nxt;

    logic [NP-1:0]     w_pick_gnt;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic [APP_AW-1:0] w_sel_addr;
    logic [BL-1:0]     w_sel_len;
    logic              w_sel_wr_n;
    logic              w_in_wdat;
    logic              w_in_rdat;
    logic              w_wr_done;
    logic              w_rd_done;

    sdrc_rr_pick #(
        .NP (NP),
        .IW (IW)
    ) u_pick (
        .i_req    (p_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_pick_gnt),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_sel_addr = p_addr[32'(w_pick_idx) * APP_AW +: APP_AW];
    assign w_sel_len  = p_len[32'(w_pick_idx) * BL +: BL];
    assign w_sel_wr_n = p_wr_n[w_pick_idx];

    assign w_in_wdat = (r_state == ARB_WDAT);
    assign w_in_rdat = (r_state == ARB_RDAT);
    // Write burst ends on the controller's last strobe or on the final counted beat.
    assign w_wr_done = w_in_wdat && (app_last_wr || (app_wr_next_req && (r_cnt == BL'(1))));
    assign w_rd_done = w_in_rdat && app_rd_valid && app_last_rd;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state  <= ARB_IDLE;
            r_gnt    <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= IW'(NP - 1);
            r_addr   <= '0;
            r_len    <= '0;
            r_wr_n   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_addr   <= w_addr_nxt;
            r_len    <= w_len_nxt;
            r_wr_n   <= w_wr_n_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_wr_n_nxt  = r_wr_n;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_REQ;
                    w_gnt_nxt   = w_pick_gnt;
                    w_gidx_nxt  = w_pick_idx;
                    w_addr_nxt  = w_sel_addr;
                    w_len_nxt   = w_sel_len;
                    w_wr_n_nxt  = w_sel_wr_n;
                end
            end
            ARB_REQ: begin
                if (app_req_ack) begin
                    // In priority mode port 0 grants leave the rotation untouched.
                    if (!(ARB_PORT0_PRIO && (r_gidx == '0))) begin
                        w_rr_nxt = r_gidx;
                    end
                    w_cnt_nxt   = (r_len == '0) ? BL'(1) : r_len;
                    w_state_nxt = r_wr_n ? ARB_RDAT : ARB_WDAT;
                end
            end
            ARB_WDAT: begin
                if (app_wr_next_req) begin
                    w_cnt_nxt = r_cnt - BL'(1);
                end
                if (w_wr_done) begin
                    w_state_nxt = ARB_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            ARB_RDAT: begin
                if (w_rd_done) begin
                    w_state_nxt = ARB_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign app_req      = (r_state == ARB_REQ);
    assign app_req_addr = r_addr;
    assign app_req_len  = r_len;
    assign app_req_wr_n = r_wr_n;
    assign arb_busy     = (r_state != ARB_IDLE);
    assign arb_gnt      = r_gnt;

    // Data-phase steering; strobes outside the data states are not routed.
    assign app_wr_data = w_in_wdat ? p_wr_data[32'(r_gidx) * APP_DW +: APP_DW] : '0;
    assign app_wr_en_n = w_in_wdat ? p_wr_en_n[32'(r_gidx) * APP_BW +: APP_BW] : '1;
    assign p_ack       = ((r_state == ARB_REQ) && app_req_ack) ? r_gnt : '0;
    assign p_wr_next   = (w_in_wdat && app_wr_next_req) ? r_gnt : '0;
    assign p_rd_valid  = (w_in_rdat && app_rd_valid) ? r_gnt : '0;
    assign p_rd_data   = w_in_rdat ? app_rd_data : '0;
    assign p_last      = (w_wr_done || w_rd_done) ? r_gnt : '0;

    // A granted requester must hold p_req until it sees p_ack.
    a_req_held: assert property (@(posedge sdram_clk) disable iff (!sdram_resetn)
        (r_state == ARB_REQ) |-> |(p_req & r_gnt))
        else $error("sdrc_app_arb: granted requester dropped p_req before p_ack");

endmodule
